// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one decoded MIPS ALU operation at a time and holds the captured result on a valid/ready port.
// Optional ALU_OP_SEQUENCER_ORI_EN makes AluOp 11 decode to OR (immediate-OR path); otherwise it is illegal.
module alu_op_sequencer (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        InValid,
    output logic        InReady,
    input  logic [31:0] InA,
    input  logic [31:0] InB,
    input  logic [1:0]  AluOp,
    input  logic [5:0]  Funct,
    output logic [3:0]  AluControl,
    output logic [31:0] AluIn1,
    output logic [31:0] AluIn2,
    input  logic [31:0] AluOut,
    input  logic        AluZero,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] Result,
    output logic        ResultZero,
    output logic        Illegal
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d, dec_code;
    logic [31:0] in1_q, in1_d, in2_q, in2_d, res_q, res_d;
    logic        zero_q, zero_d, ill_q, ill_d, accept;
    // Code 15 is reserved for illegal requests; no legal operation maps to it.
    always_comb begin
        dec_code = 4'd15;
        case (AluOp)
            2'b00: dec_code = 4'd2;
            2'b01: dec_code = 4'd6;
            2'b10:
                case (Funct)
                    6'b100000: dec_code = 4'd2;
                    6'b100010: dec_code = 4'd6;
                    6'b100100: dec_code = 4'd0;
                    6'b100101: dec_code = 4'd1;
                    6'b100111: dec_code = 4'd12;
                    6'b101010: dec_code = 4'd7;
                    default:   dec_code = 4'd15;
                endcase
            default:
`ifdef ALU_OP_SEQUENCER_ORI_EN
                dec_code = 4'd1;
`else
                dec_code = 4'd15;
`endif
        endcase
    end
    always_ff @(posedge Clock) begin
        if (Reset) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = InValid ? ISSUE : IDLE;
            ISSUE:   state_d = DONE;
            DONE:    state_d = OutReady ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        InReady  = state_q == IDLE;
        OutValid = state_q == DONE;
    end
    assign accept = state_q == IDLE && InValid;
    always_comb begin
        ctrl_d = accept ? dec_code : ctrl_q;
        in1_d  = accept ? InA : in1_q;
        in2_d  = accept ? InB : in2_q;
        ill_d  = accept ? dec_code == 4'd15 : ill_q;
        res_d  = state_q == ISSUE ? (ill_q ? 32'd0 : AluOut) : res_q;
        zero_d = state_q == ISSUE ? (!ill_q && AluZero) : zero_q;
    end
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ctrl_q <= '0;
            in1_q  <= '0;
            in2_q  <= '0;
            ill_q  <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            in1_q  <= in1_d;
            in2_q  <= in2_d;
            ill_q  <= ill_d;
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end
    assign AluControl = ctrl_q;
    assign AluIn1     = in1_q;
    assign AluIn2     = in2_q;
    assign Result     = res_q;
    assign ResultZero = zero_q;
    assign Illegal    = ill_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of alu_op_sequencer against an operation-level reference model.
module tb_alu_op_sequencer;
    logic        Clock, Reset, InValid, InReady, AluZero, OutValid, OutReady, ResultZero, Illegal;
    logic [31:0] InA, InB, AluIn1, AluIn2, AluOut, Result;
    logic [1:0]  AluOp;
    logic [5:0]  Funct;
    logic [3:0]  AluControl;
    int checks = 0, failures = 0;
    logic [31:0] last_res;
    logic [5:0]  functs [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00};

    alu_op_sequencer dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .AluOp(AluOp), .Funct(Funct),
        .AluControl(AluControl), .AluIn1(AluIn1), .AluIn2(AluIn2),
        .AluOut(AluOut), .AluZero(AluZero), .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .ResultZero(ResultZero), .Illegal(Illegal)
    );

    initial begin
        Clock = 0;
        forever #5 Clock = ~Clock;
    end

    // Combinational ALU stand-in; unknown codes return a marker value.
    always_comb begin
        case (AluControl)
            4'd0:    AluOut = AluIn1 & AluIn2;
            4'd1:    AluOut = AluIn1 | AluIn2;
            4'd2:    AluOut = AluIn1 + AluIn2;
            4'd6:    AluOut = AluIn1 - AluIn2;
            4'd7:    AluOut = {31'd0, $signed(AluIn1) < $signed(AluIn2)};
            4'd12:   AluOut = ~(AluIn1 | AluIn2);
            default: AluOut = 32'hDEADBEEF;
        endcase
        AluZero = AluOut == 32'd0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [3:0] code, output logic [31:0] r, output logic ill);
        ill = 0;
        code = 4'd15;
        r = 0;
        if (op == 2'b00) begin code = 2; r = a + b; end
        else if (op == 2'b01) begin code = 6; r = a - b; end
        else if (op == 2'b10) begin
            if (f == 6'h20) begin code = 2; r = a + b; end
            else if (f == 6'h22) begin code = 6; r = a - b; end
            else if (f == 6'h24) begin code = 0; r = a & b; end
            else if (f == 6'h25) begin code = 1; r = a | b; end
            else if (f == 6'h27) begin code = 12; r = ~(a | b); end
            else if (f == 6'h2a) begin code = 7; r = ($signed(a) < $signed(b)) ? 1 : 0; end
            else ill = 1;
        end else begin
`ifdef ALU_OP_SEQUENCER_ORI_EN
            code = 1; r = a | b;
`else
            ill = 1;
`endif
        end
        if (ill) begin code = 15; r = 0; end
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [3:0] code;
        logic [31:0] r;
        logic ill;
        model(op, f, a, b, code, r, ill);
        chk("ready_before", InReady, 1);
        InValid = 1; AluOp = op; Funct = f; InA = a; InB = b;
        @(posedge Clock); #1;
        InValid = 0; InA = $urandom; InB = $urandom; AluOp = 2'($urandom); Funct = 6'($urandom);
        chk("issue_ready", InReady, 0);
        chk("issue_valid", OutValid, 0);
        chk("issue_ctrl", AluControl, code);
        chk("issue_in1", AluIn1, a);
        chk("issue_in2", AluIn2, b);
        chk("issue_illegal", Illegal, ill);
        @(posedge Clock); #1;
        chk("done_valid", OutValid, 1);
        chk("done_result", Result, r);
        chk("done_zero", ResultZero, !ill && r == 0);
        chk("done_illegal", Illegal, ill);
        for (int i = 0; i < hold; i++) begin
            @(posedge Clock); #1;
            chk("hold_valid", OutValid, 1);
            chk("hold_ready", InReady, 0);
            chk("hold_result", Result, r);
        end
        last_res = Result;
        OutReady = 1;
        @(posedge Clock); #1;
        OutReady = 0;
        chk("after_valid", OutValid, 0);
        chk("after_ready", InReady, 1);
    endtask

    initial begin
        Reset = 1; InValid = 0; OutReady = 0; InA = 0; InB = 0; AluOp = 0; Funct = 0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 0;
        chk("rst_ready", InReady, 1);
        chk("rst_valid", OutValid, 0);
        chk("rst_ctrl", AluControl, 0);
        chk("rst_in1", AluIn1, 0);
        chk("rst_in2", AluIn2, 0);
        chk("rst_result", Result, 0);
        chk("rst_zero", ResultZero, 0);
        chk("rst_illegal", Illegal, 0);
        AluOp = 2'b10; Funct = 6'h24; InA = 32'h55; InB = 32'hAA;
        repeat (3) @(posedge Clock);
        #1;
        chk("idle_ready", InReady, 1);
        chk("idle_ctrl", AluControl, 0);
        chk("idle_in1", AluIn1, 0);
        chk("idle_valid", OutValid, 0);

        run_op(2'b00, 6'h0, 5, 7, 0);
        chk("add_lit", last_res, 12);
        run_op(2'b01, 6'h0, 32'h1234, 32'h1234, 0);
        chk("beq_lit", last_res, 0);
        run_op(2'b10, 6'h24, 32'hF0, 32'hF0F, 0);
        chk("and_lit", last_res, 32'h0);
        run_op(2'b10, 6'h25, 32'hF0, 32'hF0F, 0);
        chk("or_lit", last_res, 32'hFFF);
        run_op(2'b10, 6'h27, 32'hF0, 32'hF0F, 0);
        chk("nor_lit", last_res, 32'hFFFF_F000);
        run_op(2'b10, 6'h2a, 32'hF0, 32'hF0F, 0);
        chk("slt_lit", last_res, 1);
        run_op(2'b10, 6'h22, 32'hF0, 32'hF0F, 0);
        chk("sub_lit", last_res, 32'hFFFF_F1E1);
        run_op(2'b10, 6'h00, 32'h3, 32'h4, 0);
        chk("illegal_lit", last_res, 0);
        run_op(2'b11, 6'h0, 32'h10, 32'h01, 0);
`ifdef ALU_OP_SEQUENCER_ORI_EN
        chk("ori_lit", last_res, 32'h11);
`else
        chk("ori_lit", last_res, 0);
`endif

        // Backpressure with a competing request held pending during DONE.
        InValid = 1; AluOp = 2'b00; InA = 32'd100; InB = 32'd23;
        @(posedge Clock); #1;
        AluOp = 2'b01; InA = 32'd9; InB = 32'd4;
        @(posedge Clock); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", OutValid, 1);
            chk("bp_ready", InReady, 0);
            chk("bp_result", Result, 123);
            chk("bp_in1", AluIn1, 100);
            @(posedge Clock); #1;
        end
        OutReady = 1;
        @(posedge Clock); #1;
        OutReady = 0;
        chk("bp_release_ready", InReady, 1);
        chk("bp_release_valid", OutValid, 0);
        @(posedge Clock); #1;
        InValid = 0;
        chk("bp_next_ctrl", AluControl, 6);
        chk("bp_next_in1", AluIn1, 9);
        @(posedge Clock); #1;
        chk("bp_next_result", Result, 5);
        OutReady = 1;
        @(posedge Clock); #1;
        OutReady = 0;

        // Reset during ISSUE discards the operation.
        InValid = 1; AluOp = 2'b00; InA = 32'd1; InB = 32'd2;
        @(posedge Clock); #1;
        InValid = 0; Reset = 1;
        @(posedge Clock); #1;
        Reset = 0;
        chk("midrst_valid", OutValid, 0);
        chk("midrst_ready", InReady, 1);
        chk("midrst_ctrl", AluControl, 0);
        chk("midrst_in1", AluIn1, 0);
        repeat (2) @(posedge Clock);
        #1;
        chk("midrst_valid_later", OutValid, 0);
        chk("midrst_result", Result, 0);

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? 32'h7 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_op(2'($urandom_range(0, 3)), functs[$urandom_range(0, 6)] ^ (($urandom_range(0, 7) == 0) ? 6'h01 : 6'h00),
                   a, b, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
